onehot_decoder_seq: RTL and testbench



---
 rtl/onehot_decoder_seq.sv | 73 +++++++
 tb/tb_onehot_decoder_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: buffered 2-to-4 decoder playing each code as a held one-hot pulse
module onehot_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [1:0]                 in_code,
  output logic                       in_ready,
  input  logic [HOLD_W-1:0]          hold_cycles,
  output logic [3:0]                 Y,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic IDLE = 1'b0;
  localparam logic DRIVE = 1'b1;
  logic [1:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              state;
  logic [HOLD_W-1:0] cnt, cnt_load;
  logic              push, pop;
  logic [3:0]        y_load;
  // handshake, pop decision from registered occupancy, and next pulse shape
  always_comb begin
    in_ready = (count != CW'(DEPTH)) && !rst;
    push = in_valid && in_ready;
    pop = (count != '0) && ((state == IDLE) || (cnt == '0));
    cnt_load = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
    y_load = 4'b0001 << mem[rd_ptr];
  end
  // FIFO storage needs no reset; stale entries are never read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  // pulse sequencer: load on pop, count down the hold, chain codes without gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Y <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        Y <= y_load;
        cnt <= cnt_load;
        state <= DRIVE;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (pop) begin
      Y <= y_load;
      cnt <= cnt_load;
    end else begin
      Y <= '0;
      state <= IDLE;
    end
  end
  assign busy = (state == DRIVE);
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: random and directed checks against a queue-based pulse model
module tb_onehot_decoder_seq;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = '0;
  logic       in_ready;
  logic [3:0] hold_cycles = '0;
  logic [3:0] Y;
  logic       busy;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [1:0] m_q [$];
  int         m_left = 0;
  logic [1:0] m_cur = '0;
  onehot_decoder_seq #(.DEPTH(DEPTH), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .hold_cycles(hold_cycles), .Y(Y), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_left = 0;
  endtask
  task automatic tick(input logic v, input logic [1:0] c, input logic [3:0] h);
    bit         do_pop, acc;
    logic [3:0] exp_y;
    in_valid = v;
    in_code = c;
    hold_cycles = h;
    #1;
    check("in_ready", in_ready, m_q.size() < DEPTH);
    do_pop = (m_left <= 1) && (m_q.size() > 0);
    acc = v && (m_q.size() < DEPTH);
    @(posedge clk);
    if (m_left > 1) m_left--;
    else if (do_pop) begin
      m_cur = m_q.pop_front();
      m_left = (h == 0) ? 1 : int'(h);
    end else m_left = 0;
    if (acc) m_q.push_back(c);
    @(negedge clk);
    exp_y = (m_left > 0) ? (4'b0001 << m_cur) : 4'b0000;
    check("Y", Y, exp_y);
    check("busy", busy, m_left > 0);
    check("count", count, m_q.size());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, hold_cycles);
  endtask
  logic [3:0] b2b_exp [7] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
  initial begin
    #1;
    check("rst_y", Y, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("ready_after_rst", in_ready, 1);
    @(negedge clk);
    tick(1'b1, 2'd2, 4'd3);
    check("single_pre", Y, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'd0, 4'd3);
      check("single_y", Y, 4'b0100);
    end
    tick(1'b0, 2'd0, 4'd3);
    check("single_end", Y, 0);
    idle(2);
    tick(1'b1, 2'd3, 4'd2);
    tick(1'b1, 2'd0, 4'd2);
    check("b2b_y", Y, b2b_exp[0]);
    tick(1'b1, 2'd1, 4'd2);
    check("b2b_y", Y, b2b_exp[1]);
    for (int i = 2; i < 7; i++) begin
      tick(1'b0, 2'd0, 4'd2);
      check("b2b_y", Y, b2b_exp[i]);
    end
    idle(2);
    tick(1'b1, 2'd1, 4'd0);
    tick(1'b0, 2'd0, 4'd0);
    check("hold0_y", Y, 4'b0010);
    tick(1'b0, 2'd0, 4'd0);
    check("hold0_end", Y, 0);
    idle(1);
    for (int i = 0; i < 5; i++) tick(1'b1, 2'(i), 4'd15);
    check("full_count", count, 4);
    #1;
    check("full_ready", in_ready, 0);
    for (int i = 0; i < 14; i++) tick(1'b1, 2'd3, 4'd15);
    idle(90);
    check("drained", busy, 0);
    tick(1'b1, 2'd1, 4'd2);
    tick(1'b0, 2'd0, 4'd2);
    tick(1'b0, 2'd0, 4'd2);
    check("edge_hold", Y, 4'b0010);
    tick(1'b1, 2'd2, 4'd2);
    check("edge_gap", Y, 0);
    tick(1'b0, 2'd0, 4'd2);
    check("edge_new", Y, 4'b0100);
    idle(3);
    for (int i = 0; i < 4; i++) tick(1'b1, 2'(i), 4'd9);
    check("pre_rst_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_y", Y, 0);
    check("arst_busy", busy, 0);
    check("arst_count", count, 0);
    check("arst_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check("rand_arst_y", Y, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick(1'($urandom_range(0, 2) != 0), 2'($urandom), 4'($urandom_range(0, 4)));
      end
    end
    idle(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
